// File: rtl/seven_segment_pkg.sv
// Shared types and constants for the 7-segment readback monitor.
// Segment vectors are active-high {A,B,C,D,E,F,G}, A in bit 6.
package seven_segment_pkg;

  typedef logic [6:0] seg_t;

  localparam seg_t SEG_BLANK = 7'b0000000;

  // Indexed by the hex nibble the pattern represents.
  localparam seg_t SEG_PATTERNS [16] = '{
    7'b1111110,  // 0
    7'b0110000,  // 1
    7'b1101101,  // 2
    7'b1111001,  // 3
    7'b0110011,  // 4
    7'b1011011,  // 5
    7'b1011111,  // 6
    7'b1110000,  // 7
    7'b1111111,  // 8
    7'b1111011,  // 9
    7'b1110111,  // A
    7'b0011111,  // B
    7'b0001101,  // C
    7'b0111101,  // D
    7'b1001111,  // E
    7'b1000111   // F
  };

  typedef enum logic [1:0] {
    RUN_IDLE,
    RUN_COUNTING,
    RUN_HELD
  } run_state_t;

endpackage

// File: rtl/seven_segment_pattern_lookup.sv
// Combinational reverse lookup: active-high segment pattern to hex nibble.
// hit is low for any pattern outside the 16-entry table, including blank.
module seven_segment_pattern_lookup
  import seven_segment_pkg::*;
(
  input  seg_t       seg,
  output logic [3:0] nibble,
  output logic       hit
);

  always_comb begin
    nibble = '0;
    hit    = 1'b0;
    for (int unsigned i = 0; i < 16; i++) begin
      if (seg != SEG_BLANK && seg == SEG_PATTERNS[4'(i)]) begin
        nibble = 4'(i);
        hit    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/seven_segment_readback.sv
// Recovers per-digit hex values from the multiplexed active-low 7-segment
// drive: input register, stability run counter, capture and frame tracking.
module seven_segment_readback
  import seven_segment_pkg::*;
#(
  parameter int DIGITS        = 4,
  parameter int STABLE_CYCLES = 4
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [DIGITS-1:0]     AN,
  input  logic                  CA,
  input  logic                  CB,
  input  logic                  CC,
  input  logic                  CD,
  input  logic                  CE,
  input  logic                  CF,
  input  logic                  CG,
  input  logic                  DP,
  output logic [4*DIGITS-1:0]   digits,
  output logic [DIGITS-1:0]     dp_out,
  output logic [DIGITS-1:0]     digit_valid,
  output logic [DIGITS-1:0]     pattern_error,
  output logic                  frame_done
);

  localparam logic [7:0] RUN_TARGET = 8'(STABLE_CYCLES);

  // Registered samples, already converted to active-high.
  logic [DIGITS-1:0] smp_sel;
  seg_t              smp_seg;
  logic              smp_dp;
  logic [DIGITS-1:0] prev_sel;
  seg_t              prev_seg;
  logic              prev_dp;

  run_state_t        run_state;
  logic [7:0]        run_count;

  logic              cap_pending;
  logic [DIGITS-1:0] cap_sel;
  seg_t              cap_seg;
  logic              cap_dp;

  logic [DIGITS-1:0] seen;
  logic [DIGITS-1:0] seen_next;

  logic              selectable;
  logic              same;
  logic [3:0]        cap_nibble;
  logic              cap_hit;

  assign selectable = $onehot(smp_sel);
  assign same       = (smp_sel == prev_sel) && (smp_seg == prev_seg) &&
                      (smp_dp == prev_dp);
  assign seen_next  = seen | cap_sel;

  seven_segment_pattern_lookup u_lookup (
    .seg    (cap_seg),
    .nibble (cap_nibble),
    .hit    (cap_hit)
  );

  // The capture is staged in cap_* so the lookup sits between two registers
  // and the outputs land one edge after the run counter saturates.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      smp_sel     <= '0;
      smp_seg     <= '0;
      smp_dp      <= 1'b0;
      prev_sel    <= '0;
      prev_seg    <= '0;
      prev_dp     <= 1'b0;
      run_state   <= RUN_IDLE;
      run_count   <= '0;
      cap_pending <= 1'b0;
      cap_sel     <= '0;
      cap_seg     <= '0;
      cap_dp      <= 1'b0;
    end else begin
      smp_sel     <= ~AN;
      smp_seg     <= ~{CA, CB, CC, CD, CE, CF, CG};
      smp_dp      <= ~DP;
      prev_sel    <= smp_sel;
      prev_seg    <= smp_seg;
      prev_dp     <= smp_dp;
      cap_pending <= 1'b0;

      if (!selectable) begin
        run_state <= RUN_IDLE;
        run_count <= '0;
      end else if (run_state == RUN_IDLE || !same) begin
        run_state <= RUN_COUNTING;
        run_count <= 8'd1;
      end else if (run_state == RUN_COUNTING) begin
        run_count <= run_count + 8'd1;
        if (run_count + 8'd1 == RUN_TARGET) begin
          run_state   <= RUN_HELD;
          cap_pending <= 1'b1;
          cap_sel     <= smp_sel;
          cap_seg     <= smp_seg;
          cap_dp      <= smp_dp;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      digits        <= '0;
      dp_out        <= '0;
      digit_valid   <= '0;
      pattern_error <= '0;
      frame_done    <= 1'b0;
      seen          <= '0;
    end else begin
      frame_done <= 1'b0;
      if (cap_pending) begin
        for (int unsigned i = 0; i < DIGITS; i++) begin
          if (cap_sel[i]) begin
            if (cap_hit) begin
              digits[4*i +: 4] <= cap_nibble;
              dp_out[i]        <= cap_dp;
              digit_valid[i]   <= 1'b1;
              pattern_error[i] <= 1'b0;
            end else begin
              digit_valid[i]   <= 1'b0;
              pattern_error[i] <= 1'b1;
            end
          end
        end
        if (&seen_next) begin
          frame_done <= 1'b1;
          seen       <= '0;
        end else begin
          seen <= seen_next;
        end
      end
    end
  end

endmodule

// File: tb/tb_seven_segment_readback.sv
// Directed bench for seven_segment_readback: table of captures plus
// hand sequences for latency, short runs, illegal anodes and mid-run reset.
module tb_seven_segment_readback;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [3:0]  AN;
  logic        CA, CB, CC, CD, CE, CF, CG, DP;
  logic [15:0] digits;
  logic [3:0]  dp_out, digit_valid, pattern_error;
  logic        frame_done;

  int checks = 0;
  int errors = 0;

  int cyc       = 0;
  int pulses    = 0;
  int pulse_cyc = -1;
  int rise3_cyc = -2;
  logic v3_prev = 1'b0;

  always #5 clk = ~clk;

  seven_segment_readback #(.DIGITS(4), .STABLE_CYCLES(4)) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .AN            (AN),
    .CA            (CA),
    .CB            (CB),
    .CC            (CC),
    .CD            (CD),
    .CE            (CE),
    .CF            (CF),
    .CG            (CG),
    .DP            (DP),
    .digits        (digits),
    .dp_out        (dp_out),
    .digit_valid   (digit_valid),
    .pattern_error (pattern_error),
    .frame_done    (frame_done)
  );

  always @(negedge clk) begin
    cyc = cyc + 1;
    if (frame_done) begin
      pulses    = pulses + 1;
      pulse_cyc = cyc;
    end
    if (digit_valid[3] && !v3_prev) rise3_cyc = cyc;
    v3_prev = digit_valid[3];
  end

  typedef struct {
    logic [3:0]  an;
    logic [6:0]  seg_n;
    logic        dp_n;
    int          hold;
    logic [15:0] exp_digits;
    logic [3:0]  exp_valid;
    logic [3:0]  exp_err;
    logic [3:0]  exp_dp;
    int          exp_frames;
  } vec_t;

  vec_t vecs [11];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic set_inputs(input logic [3:0] an, input logic [6:0] seg_n, input logic dp_n);
    AN = an;
    {CA, CB, CC, CD, CE, CF, CG} = seg_n;
    DP = dp_n;
  endtask

  task automatic set_idle();
    set_inputs(4'b1111, 7'b1111111, 1'b1);
  endtask

  initial begin
    // active-low CA..CG patterns: 1=1001111 2=0010010 3=0000110 4=1001100
    // 5=0100100 8=0000000 A=0001000 G-only=1111110 blank=1111111
    vecs[0]  = '{4'b1110, 7'b1001111, 1'b1, 6, 16'h0001, 4'b0001, 4'b0000, 4'b0000, 0};
    vecs[1]  = '{4'b1101, 7'b0010010, 1'b1, 6, 16'h0021, 4'b0011, 4'b0000, 4'b0000, 0};
    vecs[2]  = '{4'b1011, 7'b0000110, 1'b0, 6, 16'h0321, 4'b0111, 4'b0000, 4'b0100, 0};
    vecs[3]  = '{4'b0111, 7'b1001100, 1'b1, 6, 16'h4321, 4'b1111, 4'b0000, 4'b0100, 1};
    vecs[4]  = '{4'b1011, 7'b1111110, 1'b1, 5, 16'h4321, 4'b1011, 4'b0100, 4'b0100, 1};
    vecs[5]  = '{4'b1011, 7'b0001000, 1'b1, 5, 16'h4A21, 4'b1111, 4'b0000, 4'b0000, 1};
    vecs[6]  = '{4'b1110, 7'b1111111, 1'b1, 5, 16'h4A21, 4'b1110, 4'b0001, 4'b0000, 1};
    vecs[7]  = '{4'b1110, 7'b0100100, 1'b0, 8, 16'h4A25, 4'b1111, 4'b0000, 4'b0001, 1};
    vecs[8]  = '{4'b1101, 7'b0000000, 1'b1, 4, 16'h4A85, 4'b1111, 4'b0000, 4'b0001, 1};
    vecs[9]  = '{4'b0111, 7'b0001000, 1'b1, 3, 16'h4A85, 4'b1111, 4'b0000, 4'b0001, 1};
    vecs[10] = '{4'b0111, 7'b0010010, 1'b1, 4, 16'h2A85, 4'b1111, 4'b0000, 4'b0001, 2};

    // Reset with random inputs
    reset_n = 1'b0;
    for (int k = 0; k < 2; k++) begin
      set_inputs(4'($urandom), 7'($urandom), 1'($urandom));
      @(negedge clk);
    end
    check("reset digits", 32'(digits), 32'h0);
    check("reset dp_out", 32'(dp_out), 32'h0);
    check("reset valid", 32'(digit_valid), 32'h0);
    check("reset error", 32'(pattern_error), 32'h0);
    check("reset frame pulses", 32'(pulses), 32'h0);

    reset_n = 1'b1;
    set_idle();
    repeat (2) @(negedge clk);

    // Single capture latency: visible exactly 5 edges after first sample edge
    set_inputs(4'b1110, 7'b0100100, 1'b1);
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      check($sformatf("latency valid edge t+%0d", k), 32'(digit_valid),
            (k == 5) ? 32'h1 : 32'h0);
      if (k == 3) set_idle();
    end
    check("single digit0", 32'(digits[3:0]), 32'h5);
    check("single dp_out", 32'(dp_out), 32'h0);
    check("single error", 32'(pattern_error), 32'h0);

    // Short run on digit 1, then anode moves to digit 2 briefly
    set_inputs(4'b1101, 7'b0000110, 1'b1);
    repeat (3) @(negedge clk);
    set_inputs(4'b1011, 7'b0000110, 1'b1);
    repeat (2) @(negedge clk);
    set_idle();
    repeat (3) @(negedge clk);
    check("short run valid", 32'(digit_valid), 32'h1);
    check("short run digits", 32'(digits), 32'h0005);
    check("short run pulses", 32'(pulses), 32'h0);

    // Table: full frame, bad pattern, blank, long/min/short runs
    for (int i = 0; i < 11; i++) begin
      set_inputs(vecs[i].an, vecs[i].seg_n, vecs[i].dp_n);
      repeat (vecs[i].hold) @(negedge clk);
      set_idle();
      repeat (3) @(negedge clk);
      check($sformatf("row%0d digits", i), 32'(digits), 32'(vecs[i].exp_digits));
      check($sformatf("row%0d valid", i), 32'(digit_valid), 32'(vecs[i].exp_valid));
      check($sformatf("row%0d error", i), 32'(pattern_error), 32'(vecs[i].exp_err));
      check($sformatf("row%0d dp_out", i), 32'(dp_out), 32'(vecs[i].exp_dp));
      check($sformatf("row%0d frame pulses", i), 32'(pulses), 32'(vecs[i].exp_frames));
      if (i == 3)
        check("frame_done aligned with digit3 update", 32'(pulse_cyc), 32'(rise3_cyc));
    end

    // Two anodes low: never selectable
    set_inputs(4'b1100, 7'b0000000, 1'b1);
    repeat (10) @(negedge clk);
    set_idle();
    repeat (3) @(negedge clk);
    check("two anodes digits", 32'(digits), 32'h2A85);
    check("two anodes valid", 32'(digit_valid), 32'hF);
    check("two anodes error", 32'(pattern_error), 32'h0);
    check("two anodes pulses", 32'(pulses), 32'h2);

    // Reset interrupts a run; remaining run is too short to capture
    set_inputs(4'b0111, 7'b0000000, 1'b1);
    repeat (2) @(negedge clk);
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    repeat (3) @(negedge clk);
    set_idle();
    repeat (4) @(negedge clk);
    check("midrun reset digits", 32'(digits), 32'h0);
    check("midrun reset valid", 32'(digit_valid), 32'h0);
    check("midrun reset error", 32'(pattern_error), 32'h0);
    check("midrun reset dp_out", 32'(dp_out), 32'h0);
    check("midrun reset pulses", 32'(pulses), 32'h2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
